// File: rtl/if1_inst_queue_if.sv
// Handshake bundle between the IF1 fetch return path, the instruction queue and ID.
// master = front end / ID side driving the queue; slave = the queue itself.
interface if1_inst_queue_if #(
  parameter int unsigned WORD  = 32,
  parameter int unsigned PTR_W = 2
);
  logic             flush_in;
  logic [WORD-1:0]  IF1_PC_in;
  logic [WORD-1:0]  IF1_inst_in;
  logic             ICache_valid_in;
  logic             ID_ready_in;
  logic [WORD-1:0]  IF1_ID_PC_out;
  logic [WORD-1:0]  IF1_ID_inst_out;
  logic             IF1_ID_valid_out;
  logic             IF1_stall_out;
  logic [PTR_W:0]   count_out;

  modport master (
    output flush_in, IF1_PC_in, IF1_inst_in, ICache_valid_in, ID_ready_in,
    input  IF1_ID_PC_out, IF1_ID_inst_out, IF1_ID_valid_out, IF1_stall_out, count_out
  );

  modport slave (
    input  flush_in, IF1_PC_in, IF1_inst_in, ICache_valid_in, ID_ready_in,
    output IF1_ID_PC_out, IF1_ID_inst_out, IF1_ID_valid_out, IF1_stall_out, count_out
  );
endinterface

// File: rtl/if1_inst_queue.sv
// IF1 instruction queue: show-ahead circular FIFO of {PC, inst} pairs feeding ID,
// with full back-pressure to fetch and a flush that empties it on branch redirect.
module if1_inst_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2,
  parameter int unsigned WORD  = 32
) (
  input  logic               clk,
  input  logic               rst,
  if1_inst_queue_if.slave    bus
);

  logic [WORD-1:0]  pc_mem   [DEPTH];
  logic [WORD-1:0]  inst_mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W:0]   count;
  logic             full;
  logic             empty;
  logic             enq;
  logic             deq;

  assign full  = (count == (PTR_W+1)'(DEPTH));
  assign empty = (count == '0);

  // A full queue refuses the offer even if the head drains this cycle.
  assign enq = bus.ICache_valid_in & ~full & ~bus.flush_in;
  assign deq = ~empty & bus.ID_ready_in & ~bus.flush_in;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pc_mem[i]   <= '0;
        inst_mem[i] <= '0;
      end
    end else if (bus.flush_in) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) begin
        pc_mem[wr_ptr]   <= bus.IF1_PC_in;
        inst_mem[wr_ptr] <= bus.IF1_inst_in;
        wr_ptr           <= wr_ptr + PTR_W'(1);
      end
      if (deq) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({enq, deq})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign bus.IF1_ID_PC_out    = pc_mem[rd_ptr];
  assign bus.IF1_ID_inst_out  = inst_mem[rd_ptr];
  assign bus.IF1_ID_valid_out = ~empty;
  assign bus.IF1_stall_out    = full;
  assign bus.count_out        = count;

endmodule

// File: tb/tb_if1_inst_queue.sv
// Table-driven bench for if1_inst_queue: per-cycle vectors with expected occupancy,
// plus a scoreboard of accepted {PC, inst} pairs checked whenever ID consumes the head.
module tb_if1_inst_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned PTR_W = 2;
  localparam int unsigned WORD  = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  if1_inst_queue_if #(.WORD(WORD), .PTR_W(PTR_W)) bus ();

  if1_inst_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W), .WORD(WORD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    bit          rst;
    bit          flush;
    bit          vld;
    bit          rdy;
    logic [31:0] pc;
    int          cnt;   // expected occupancy after the edge
    bit          zero;  // expect head outputs to read zero after the edge
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  vec_t   vecs[$];
  entry_t sb[$];
  int     errors = 0;
  int     checks = 0;

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return pc ^ 32'hA5A5_0013;
  endfunction

  task automatic add(input bit r, input bit f, input bit v, input bit rd,
                     input logic [31:0] pc, input int cnt, input bit zero);
    vec_t t;
    t.rst = r; t.flush = f; t.vld = v; t.rdy = rd; t.pc = pc; t.cnt = cnt; t.zero = zero;
    vecs.push_back(t);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec=%0d got=0x%08h want=0x%08h", name, idx, act, exp);
    end
  endtask

  initial begin
    int     prev;
    bit     deq;
    bit     enq;
    entry_t e;

    // Reset held two cycles with handshakes asserted
    add(1, 0, 1, 1, 32'h1c000000, 0, 1);
    add(1, 0, 1, 1, 32'h1c000000, 0, 1);
    // Fill to full, then a refused fifth offer
    add(0, 0, 1, 0, 32'h1c000000, 1, 0);
    add(0, 0, 1, 0, 32'h1c000004, 2, 0);
    add(0, 0, 1, 0, 32'h1c000008, 3, 0);
    add(0, 0, 1, 0, 32'h1c00000c, 4, 0);
    add(0, 0, 1, 0, 32'h1c000010, 4, 0);
    // Full with simultaneous deq: offer refused, then re-offer accepted
    add(0, 0, 1, 1, 32'h1c000010, 3, 0);
    add(0, 0, 1, 0, 32'h1c000010, 4, 0);
    // Drain with garbage on the data inputs while valid is low
    add(0, 0, 0, 1, 32'hdeadbeef, 3, 0);
    add(0, 0, 0, 1, 32'hcafef00d, 2, 0);
    add(0, 0, 0, 1, 32'h0badc0de, 1, 0);
    add(0, 0, 0, 1, 32'hffffffff, 0, 0);
    // Streaming 10 entries through, occupancy settles at 1, pointers wrap
    for (int i = 0; i < 10; i++)
      add(0, 0, 1, 1, 32'h1c000014 + 32'(4 * i), 1, 0);
    add(0, 0, 0, 1, 32'h12345678, 0, 0);
    // Flush with offers on both sides, then a second consecutive flush
    add(0, 0, 1, 0, 32'h1c000100, 1, 0);
    add(0, 0, 1, 0, 32'h1c000104, 2, 0);
    add(0, 0, 1, 0, 32'h1c000108, 3, 0);
    add(0, 1, 1, 1, 32'h1c000040, 0, 0);
    add(0, 1, 1, 1, 32'h1c000044, 0, 0);
    add(0, 0, 1, 0, 32'h1c000080, 1, 0);
    add(0, 0, 0, 1, 32'h00000000, 0, 0);
    // Reset mid-operation with enq and deq offered
    add(0, 0, 1, 0, 32'h1c000200, 1, 0);
    add(0, 0, 1, 0, 32'h1c000204, 2, 0);
    add(1, 0, 1, 1, 32'h1c000208, 0, 1);
    add(0, 0, 1, 0, 32'h1c00020c, 1, 0);
    add(0, 0, 0, 1, 32'h00000000, 0, 0);
    // ID ready while empty has no effect
    add(0, 0, 0, 1, 32'h00000000, 0, 0);

    rst = 1'b1;
    bus.flush_in = 1'b0; bus.ICache_valid_in = 1'b0; bus.ID_ready_in = 1'b0;
    bus.IF1_PC_in = '0; bus.IF1_inst_in = '0;

    prev = 0;
    foreach (vecs[i]) begin
      @(negedge clk);
      rst                 = vecs[i].rst;
      bus.flush_in        = vecs[i].flush;
      bus.ICache_valid_in = vecs[i].vld;
      bus.ID_ready_in     = vecs[i].rdy;
      bus.IF1_PC_in       = vecs[i].pc;
      bus.IF1_inst_in     = inst_of(vecs[i].pc);
      #1;
      // Head is purely registered: this cycle's input never shows up before the edge
      if (i > 1) chk("valid_pre", i, 32'(bus.IF1_ID_valid_out), 32'(prev != 0));

      deq = !vecs[i].rst && !vecs[i].flush && vecs[i].rdy && prev != 0;
      enq = !vecs[i].rst && !vecs[i].flush && vecs[i].vld && prev != DEPTH;
      if (deq) begin
        if (sb.size() == 0) begin
          errors++; checks++;
          $display("FAIL sb_underflow vec=%0d got=empty want=entry", i);
        end else begin
          e = sb.pop_front();
          chk("head_pc", i, bus.IF1_ID_PC_out, e.pc);
          chk("head_inst", i, bus.IF1_ID_inst_out, e.inst);
        end
      end
      if (vecs[i].rst || vecs[i].flush) sb.delete();
      else if (enq) sb.push_back('{vecs[i].pc, inst_of(vecs[i].pc)});

      @(posedge clk);
      #1;
      chk("count", i, 32'(bus.count_out), 32'(vecs[i].cnt));
      chk("valid", i, 32'(bus.IF1_ID_valid_out), 32'(vecs[i].cnt != 0));
      chk("stall", i, 32'(bus.IF1_stall_out), 32'(vecs[i].cnt == DEPTH));
      if (vecs[i].zero) begin
        chk("rst_pc", i, bus.IF1_ID_PC_out, 32'h0);
        chk("rst_inst", i, bus.IF1_ID_inst_out, 32'h0);
      end
      prev = vecs[i].cnt;
    end

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover got=%0d want=0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/if1_inst_queue.md
Name: if1_inst_queue

Overview:
- IF1-stage instruction queue, directly downstream of the IF0/IF1 pipeline register.
- Accepts {PC, instruction} pairs returned by the ICache in IF1 and buffers them in a small circular FIFO.
- Presents the oldest entry to the ID stage with a valid/ready handshake.
- Back-pressures the fetch front end when full, and discards all contents on a branch redirect.

Parameters:
- DEPTH, 4, number of entries; must be a power of 2, minimum 2.
- PTR_W, 2, pointer width; equals log2(DEPTH).
- WORD, 32, width of PC and instruction.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- flush_in  in  1  branch redirect (EX_Branch | Pre_Branch); empties the queue.
- IF1_PC_in  in  WORD  PC of the instruction returned this cycle.
- IF1_inst_in  in  WORD  instruction word from the ICache.
- ICache_valid_in  in  1  IF1_PC_in/IF1_inst_in are valid this cycle.
- ID_ready_in  in  1  ID accepts the head entry this cycle.
- IF1_ID_PC_out  out  WORD  PC of the head entry.
- IF1_ID_inst_out  out  WORD  instruction of the head entry.
- IF1_ID_valid_out  out  1  head entry is valid.
- IF1_stall_out  out  1  queue full; fetch front end must hold (feeds IF0_IF1_stall_from_ICache-style stall logic).
- count_out  out  PTR_W+1  current occupancy, 0..DEPTH.

Behaviour:
- State: storage array of DEPTH x {PC, inst}, rd_ptr, wr_ptr (PTR_W bits, wrap naturally), count (PTR_W+1 bits).
- Reset (rst=1 at clk edge): rd_ptr=0, wr_ptr=0, count=0, all storage=0. Overrides flush and all handshakes.
- Outputs after reset: IF1_ID_valid_out=0, IF1_ID_PC_out=0, IF1_ID_inst_out=0, IF1_stall_out=0, count_out=0.
- Show-ahead FIFO; head outputs are combinational from storage[rd_ptr].
  - IF1_ID_valid_out = (count!=0).
  - IF1_stall_out = (count==DEPTH).
  - count_out = count.
- enq = ICache_valid_in & ~IF1_stall_out & ~flush_in.
  - On enq: storage[wr_ptr] <= {IF1_PC_in, IF1_inst_in}; wr_ptr <= wr_ptr+1.
- deq = IF1_ID_valid_out & ID_ready_in & ~flush_in.
  - On deq: rd_ptr <= rd_ptr+1.
- Count update: count <= count + enq - deq.
  - Simultaneous enq and deq when neither full nor empty: count unchanged, both pointers advance.
- When full: enq is refused even if deq occurs in the same cycle (no bypass). The front end must hold and re-present the data.
  - Queue then holds DEPTH-1 for one cycle; IF1_stall_out drops the next cycle.
- When empty: deq is impossible. No combinational pass-through from IF1_*_in to IF1_ID_*_out; minimum latency is 1 cycle (enq edge, then visible at head).
- Pointer wrap: DEPTH-1 -> 0 by modular arithmetic, with no special casing.
- Flush (flush_in=1, rst=0):
  - Next edge: rd_ptr=0, wr_ptr=0, count=0.
  - Any enq or deq offered in the same cycle is discarded. ID must not consume an entry in a flush cycle; ID_ready_in is ignored.
  - Storage contents are not cleared; the head outputs may show stale data while IF1_ID_valid_out=0.
- Consecutive flush cycles: the queue stays empty.
- First enq after flush is accepted in the first cycle with flush_in=0.
- Reset mid-operation: identical to reset from idle; all entries lost, and outputs take their reset values after the edge.
- ID_ready_in while empty: no effect.
- X on IF1_*_in while ICache_valid_in=0: must not propagate to state.

Test Plan:
- Reset: hold rst 2 cycles with ICache_valid_in=1 and ID_ready_in=1 -> count_out=0, IF1_ID_valid_out=0, IF1_ID_PC_out=0, IF1_stall_out=0.
- Fill/stall: ID_ready_in=0; enqueue PCs 0x1c000000, 0x1c000004, 0x1c000008, 0x1c00000c in 4 cycles -> count_out=4, IF1_stall_out=1. A 5th offer of 0x1c000010 is refused; head PC=0x1c000000.
- Full with simultaneous deq: from the full state, ID_ready_in=1 and valid_in=1 with 0x1c000010 -> 0x1c000010 is not stored, count_out=3, IF1_stall_out=0. Re-offered next cycle -> accepted.
- Streaming wrap-around: valid_in=1 and ID_ready_in=1 continuously for 10 cycles with PCs incrementing by 4 -> ID receives all 10 in order, one per cycle after 1-cycle latency; count_out stays 1; pointers wrap twice.
- Flush: count_out=3; flush_in=1 with valid_in=1 (PC 0x1c000040) and ID_ready_in=1 -> next cycle count_out=0, IF1_ID_valid_out=0. PC 0x1c000040 is never delivered; the next enq 0x1c000080 appears at the head one cycle later.
- Reset mid-operation: count_out=2, assert rst for 1 cycle concurrently with enq/deq -> count_out=0, all outputs 0. Normal enq resumes on the following cycle.
